// File: rtl/prp_rct_tagger.sv
// PRP Redundancy Control Trailer tagger: duplicates one packet stream into A/B
// streams and, in PRP mode, appends a per-LAN RCT and fixes the IOQ header lengths.
module prp_rct_tagger #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [3:0] LAN_ID_A = 4'hA,
  parameter logic [3:0] LAN_ID_B = 4'hB,
  parameter logic [15:0] PRP_SUFFIX = 16'h88FB,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data_A,
  output logic [DATA_WIDTH-1:0] out_data_B,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  PRP
);

  typedef enum logic [1:0] {HDR, DATA, EXTRA} state_t;

  state_t      state;
  logic        pkt_prp;
  logic [15:0] seq;
  logic [15:0] pkt_seq;
  logic [11:0] pkt_size;
  logic [63:0] spill_A;
  logic [63:0] spill_B;
  logic [7:0]  spill_ctrl;

  logic        accept;
  logic [3:0]  last_k;
  logic [6:0]  shift_bits;
  logic [15:0] new_byte_len;
  logic [16:0] round_up;
  logic [15:0] new_word_len;
  logic [63:0] hdr_word;
  logic [47:0] rct_A;
  logic [47:0] rct_B;
  logic [63:0] keep_mask;
  logic [127:0] tagged_A;
  logic [127:0] tagged_B;
  logic [7:0]  last_ctrl_tag;
  logic [7:0]  extra_ctrl;

  // The spill decision is registered, so the stall starts the cycle after the
  // last word is accepted and lasts until the EXTRA word leaves.
  assign in_rdy = out_rdy && (state != EXTRA);
  assign accept = in_wr && in_rdy;

  always_comb begin
    last_k = 4'd8;
    case (in_ctrl)
      8'h80:   last_k = 4'd1;
      8'h40:   last_k = 4'd2;
      8'h20:   last_k = 4'd3;
      8'h10:   last_k = 4'd4;
      8'h08:   last_k = 4'd5;
      8'h04:   last_k = 4'd6;
      8'h02:   last_k = 4'd7;
      default: last_k = 4'd8;
    endcase
  end

  assign new_byte_len = in_data[15:0] + 16'd6;
  assign round_up     = {1'b0, new_byte_len} + 17'd7;
  assign new_word_len = {2'b00, round_up[16:3]};
  assign hdr_word     = {in_data[63:48], new_word_len, in_data[31:16], new_byte_len};

  assign rct_A = {pkt_seq, LAN_ID_A, pkt_size, PRP_SUFFIX};
  assign rct_B = {pkt_seq, LAN_ID_B, pkt_size, PRP_SUFFIX};

  // Byte 0 sits at the MSB; a 128-bit window holds the last word and its spill.
  assign shift_bits = {last_k, 3'b000};
  assign keep_mask  = ~(64'hFFFF_FFFF_FFFF_FFFF >> shift_bits);
  assign tagged_A   = {in_data & keep_mask, 64'h0} | ({rct_A, 80'h0} >> shift_bits);
  assign tagged_B   = {in_data & keep_mask, 64'h0} | ({rct_B, 80'h0} >> shift_bits);

  assign last_ctrl_tag = (last_k <= 4'd2) ? (8'h04 >> last_k) : 8'h01;
  assign extra_ctrl    = 8'h04 << (4'd8 - last_k);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR;
      pkt_prp    <= 1'b0;
      seq        <= '0;
      pkt_seq    <= '0;
      pkt_size   <= '0;
      spill_A    <= '0;
      spill_B    <= '0;
      spill_ctrl <= '0;
      out_wr     <= 1'b0;
      out_data_A <= '0;
      out_data_B <= '0;
      out_ctrl   <= '0;
    end else begin
      out_wr <= 1'b0;
      if (accept) begin
        out_wr     <= 1'b1;
        out_data_A <= in_data;
        out_data_B <= in_data;
        out_ctrl   <= in_ctrl;
        case (state)
          HDR: begin
            if (in_ctrl == '0) begin
              state <= DATA;
            end else if (in_ctrl == IOQ_CTRL) begin
              pkt_prp <= PRP;
              if (PRP) begin
                out_data_A <= hdr_word;
                out_data_B <= hdr_word;
                pkt_seq    <= seq;
                seq        <= seq + 16'd1;
                pkt_size   <= in_data[11:0] - 12'd8;
              end
            end
          end
          DATA: begin
            if (in_ctrl != '0) begin
              state <= HDR;
              if (pkt_prp) begin
                out_data_A <= tagged_A[127:64];
                out_data_B <= tagged_B[127:64];
                out_ctrl   <= last_ctrl_tag;
                spill_A    <= tagged_A[63:0];
                spill_B    <= tagged_B[63:0];
                spill_ctrl <= extra_ctrl;
                if (last_k >= 4'd3) state <= EXTRA;
              end
            end
          end
          default: ;
        endcase
      end else if (state == EXTRA && out_rdy) begin
        out_wr     <= 1'b1;
        out_data_A <= spill_A;
        out_data_B <= spill_B;
        out_ctrl   <= spill_ctrl;
        state      <= HDR;
      end
    end
  end

endmodule

// File: tb/tb_prp_rct_tagger.sv
// Directed bench for prp_rct_tagger: passthrough, RCT placement for several
// last-word lengths, EXTRA backpressure, mid-packet reset and sequence wrap.
module tb_prp_rct_tagger;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data_A;
  logic [63:0] out_data_B;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        PRP;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  prp_rct_tagger dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data_A(out_data_A), .out_data_B(out_data_B), .out_ctrl(out_ctrl),
    .out_wr(out_wr), .out_rdy(out_rdy), .PRP(PRP)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Entered and left on a negedge; the accepted word is visible on return.
  task automatic applyStimulus(input logic [7:0] c, input logic [63:0] d);
    int guard = 0;
    while (!in_rdy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("in_rdy_timeout", {63'b0, in_rdy}, 64'd1);
    in_ctrl = c;
    in_data = d;
    in_wr   = 1'b1;
    @(negedge clk);
    in_wr   = 1'b0;
  endtask

  task automatic sendPacket(input string name, input logic prp,
                            input logic [63:0] hdr, input logic [63:0] exp_hdr,
                            input int n_pay, input logic [7:0] last_ctrl,
                            input logic [63:0] last_data,
                            input logic [63:0] exp_last_A, input logic [63:0] exp_last_B,
                            input logic [7:0] exp_last_ctrl,
                            input logic has_extra, input int hold,
                            input logic [63:0] exp_extra_A, input logic [63:0] exp_extra_B,
                            input logic [7:0] exp_extra_ctrl);
    logic [63:0] pay;
    PRP = prp;
    applyStimulus(8'hFF, hdr);
    PRP = ~prp;
    checkOutput({name, ".hdr_wr"}, {63'b0, out_wr}, 64'd1);
    checkOutput({name, ".hdr_A"}, out_data_A, exp_hdr);
    checkOutput({name, ".hdr_B"}, out_data_B, exp_hdr);
    for (int i = 0; i < n_pay; i++) begin
      pay = 64'h0123_4567_89AB_CD00 | 64'(i);
      applyStimulus(8'h00, pay);
      checkOutput({name, ".pay_A"}, out_data_A, pay);
      checkOutput({name, ".pay_B"}, out_data_B, pay);
      checkOutput({name, ".pay_ctrl"}, {56'b0, out_ctrl}, 64'd0);
    end
    applyStimulus(last_ctrl, last_data);
    checkOutput({name, ".last_wr"}, {63'b0, out_wr}, 64'd1);
    checkOutput({name, ".last_A"}, out_data_A, exp_last_A);
    checkOutput({name, ".last_B"}, out_data_B, exp_last_B);
    checkOutput({name, ".last_ctrl"}, {56'b0, out_ctrl}, {56'b0, exp_last_ctrl});
    if (has_extra) begin
      checkOutput({name, ".stall_rdy"}, {63'b0, in_rdy}, 64'd0);
      if (hold > 0) out_rdy = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checkOutput({name, ".held_wr"}, {63'b0, out_wr}, 64'd0);
      end
      out_rdy = 1'b1;
      @(negedge clk);
      checkOutput({name, ".extra_wr"}, {63'b0, out_wr}, 64'd1);
      checkOutput({name, ".extra_A"}, out_data_A, exp_extra_A);
      checkOutput({name, ".extra_B"}, out_data_B, exp_extra_B);
      checkOutput({name, ".extra_ctrl"}, {56'b0, out_ctrl}, {56'b0, exp_extra_ctrl});
    end
    checkOutput({name, ".rdy_after"}, {63'b0, in_rdy}, 64'd1);
  endtask

  initial begin
    reset   = 1'b1;
    in_data = '0;
    in_ctrl = '0;
    in_wr   = 1'b0;
    out_rdy = 1'b1;
    PRP     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset.wr", {63'b0, out_wr}, 64'd0);
    checkOutput("reset.A", out_data_A, 64'd0);
    checkOutput("reset.B", out_data_B, 64'd0);
    checkOutput("reset.ctrl", {56'b0, out_ctrl}, 64'd0);

    sendPacket("pt60", 1'b0, 64'h0004_0008_0001_003C, 64'h0004_0008_0001_003C,
               7, 8'h10, 64'hDEAD_BEEF_1234_5678,
               64'hDEAD_BEEF_1234_5678, 64'hDEAD_BEEF_1234_5678, 8'h10,
               1'b0, 0, 64'h0, 64'h0, 8'h00);

    sendPacket("prp60", 1'b1, 64'h0004_0008_0001_003C, 64'h0004_0009_0001_0042,
               7, 8'h10, 64'hDEAD_BEEF_1234_5678,
               64'hDEAD_BEEF_0000_A034, 64'hDEAD_BEEF_0000_B034, 8'h01,
               1'b1, 0, 64'h88FB_0000_0000_0000, 64'h88FB_0000_0000_0000, 8'h40);

    sendPacket("prp58", 1'b1, 64'h0004_0008_0001_003A, 64'h0004_0008_0001_0040,
               7, 8'h40, 64'hCAFE_1122_3344_5566,
               64'hCAFE_0001_A032_88FB, 64'hCAFE_0001_B032_88FB, 8'h01,
               1'b0, 0, 64'h0, 64'h0, 8'h00);

    sendPacket("prp57", 1'b1, 64'h0004_0008_0001_0039, 64'h0004_0008_0001_003F,
               7, 8'h80, 64'h7711_2233_4455_6677,
               64'h7700_02A0_3188_FB00, 64'h7700_02B0_3188_FB00, 8'h02,
               1'b0, 0, 64'h0, 64'h0, 8'h00);

    sendPacket("stall20", 1'b1, 64'h0004_0003_0001_0014, 64'h0004_0004_0001_001A,
               2, 8'h10, 64'h0102_0304_FFFF_FFFF,
               64'h0102_0304_0003_A00C, 64'h0102_0304_0003_B00C, 8'h01,
               1'b1, 3, 64'h88FB_0000_0000_0000, 64'h88FB_0000_0000_0000, 8'h40);

    sendPacket("full16", 1'b1, 64'h0004_0002_0001_0010, 64'h0004_0003_0001_0016,
               1, 8'h01, 64'h1122_3344_5566_7788,
               64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 8'h01,
               1'b1, 0, 64'h0004_A008_88FB_0000, 64'h0004_B008_88FB_0000, 8'h04);

    // Abandon a PRP packet mid-payload; seq and parser state must restart.
    PRP = 1'b1;
    applyStimulus(8'hFF, 64'h0004_0008_0001_003C);
    applyStimulus(8'h00, 64'h5555_5555_5555_5555);
    applyStimulus(8'h00, 64'h6666_6666_6666_6666);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst.wr", {63'b0, out_wr}, 64'd0);
    checkOutput("midrst.A", out_data_A, 64'd0);
    checkOutput("midrst.B", out_data_B, 64'd0);
    checkOutput("midrst.ctrl", {56'b0, out_ctrl}, 64'd0);
    checkOutput("midrst.rdy", {63'b0, in_rdy}, 64'd1);

    sendPacket("clean58", 1'b1, 64'h0004_0008_0001_003A, 64'h0004_0008_0001_0040,
               7, 8'h40, 64'hCAFE_1122_3344_5566,
               64'hCAFE_0000_A032_88FB, 64'hCAFE_0000_B032_88FB, 8'h01,
               1'b0, 0, 64'h0, 64'h0, 8'h00);

    // Back-to-back IOQ headers advance seq from 1 to 0xFFFF quickly.
    PRP     = 1'b1;
    in_ctrl = 8'hFF;
    in_data = 64'h0004_0001_0001_0008;
    in_wr   = 1'b1;
    repeat (65534) @(negedge clk);
    in_wr   = 1'b0;
    checkOutput("burst.hdr_A", out_data_A, 64'h0004_0002_0001_000E);

    sendPacket("wrapFFFF", 1'b1, 64'h0004_0008_0001_003A, 64'h0004_0008_0001_0040,
               7, 8'h40, 64'hCAFE_1122_3344_5566,
               64'hCAFE_FFFF_A032_88FB, 64'hCAFE_FFFF_B032_88FB, 8'h01,
               1'b0, 0, 64'h0, 64'h0, 8'h00);

    sendPacket("wrap0000", 1'b1, 64'h0004_0008_0001_003A, 64'h0004_0008_0001_0040,
               7, 8'h40, 64'hCAFE_1122_3344_5566,
               64'hCAFE_0000_A032_88FB, 64'hCAFE_0000_B032_88FB, 8'h01,
               1'b0, 0, 64'h0, 64'h0, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
